// File: rtl/chan_512_fir_seq_pkg.sv
// Shared state type and ctrl/status bit positions for the chan_512 FIR
// coefficient sequencer.
package chan_512_fir_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_SYNC,
        ST_SWAP,
        ST_ACK
    } state_e;

    localparam int CTRL_TOGGLE = 31;
    localparam int CTRL_COMMIT = 30;
    localparam int CTRL_CLEAR  = 29;
    // Every bit below the command bits is address, so out-of-range pairs are
    // rejected rather than aliased onto a valid pair.
    localparam int CTRL_ADDR_W = 29;

    localparam int STAT_ACK      = 31;
    localparam int STAT_BUSY     = 30;
    localparam int STAT_BANK     = 29;
    localparam int STAT_TMO      = 28;
    localparam int STAT_AERR     = 27;
    localparam int STAT_OVR_LSB  = 8;
    localparam int STAT_WCNT_LSB = 0;

endpackage

// File: rtl/chan_512_toggle_det.sv
// Toggle edge detector; the first cycle after reset only loads the reference
// level so a toggle bit already high at reset release is not seen as a command.
module chan_512_toggle_det (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic toggle_i,
    output logic edge_o
);

    logic prev_q;
    logic init_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= 1'b0;
            init_q <= 1'b0;
        end else begin
            prev_q <= toggle_i;
            init_q <= 1'b1;
        end
    end

    assign edge_o = init_q && (toggle_i != prev_q);

endmodule

// File: rtl/chan_512_fir_coef_seq.sv
// chan_512 FIR coefficient sequencer: shadow-bank pair writes and sync-aligned
// bank swap. Optional WAIT_SYNC timeout enabled by FIR_SEQ_TIMEOUT_EN.
module chan_512_fir_coef_seq
    import chan_512_fir_seq_pkg::*;
#(
    parameter int NUM_PAIRS    = 8,
    parameter int ADDR_W       = 3,
    parameter int COEF_W       = 16,
    parameter int SYNC_TIMEOUT = 1024
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic [31:0]           ctrl_reg,
    input  logic [31:0]           data_reg,
    input  logic                  sync_in,
    output logic                  coef_we,
    output logic                  coef_bank,
    output logic [ADDR_W-1:0]     coef_addr,
    output logic [2*COEF_W-1:0]   coef_wdata,
    output logic                  active_bank,
    output logic [31:0]           status_out
);

    // state     | meaning
    // IDLE      | waiting for a command toggle
    // WRITE     | one-cycle coef_we into the shadow bank
    // WAIT_SYNC | commit pending, waiting for the frame sync
    // SWAP      | banks swapped this cycle
    // ACK       | ack toggle presented, back to IDLE next

    localparam logic [CTRL_ADDR_W-1:0] PAIR_LIMIT = CTRL_ADDR_W'(NUM_PAIRS);

    state_e                  state_q;
    logic                    cmd;
    logic                    tog_cap_q;
    logic                    we_q;
    logic                    active_q;
    logic                    ack_q;
    logic                    aerr_q;
    logic                    tmo_flag;
    logic [ADDR_W-1:0]       addr_q;
    logic [2*COEF_W-1:0]     wdata_q;
    logic [7:0]              ovr_q;
    logic [7:0]              ovr_d;
    logic [7:0]              wcnt_q;
    logic [CTRL_ADDR_W-1:0]  cmd_addr;

`ifdef FIR_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(SYNC_TIMEOUT);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_q;
    assign tmo_flag = tmo_q;
`else
    assign tmo_flag = 1'b0;
`endif

    chan_512_toggle_det u_toggle_det (
        .clk_i    (user_clk),
        .rst_n_i  (user_rst_n),
        .toggle_i (ctrl_reg[CTRL_TOGGLE]),
        .edge_o   (cmd)
    );

    assign cmd_addr = ctrl_reg[CTRL_ADDR_W-1:0];
    assign ovr_d    = (ovr_q == 8'hFF) ? ovr_q : ovr_q + 8'd1;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q   <= ST_IDLE;
            tog_cap_q <= 1'b0;
            we_q      <= 1'b0;
            active_q  <= 1'b0;
            ack_q     <= 1'b0;
            aerr_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ovr_q     <= '0;
            wcnt_q    <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            if (cmd && state_q != ST_IDLE) begin
                ovr_q <= ovr_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmd) begin
                        tog_cap_q <= ctrl_reg[CTRL_TOGGLE];
                        if (ctrl_reg[CTRL_CLEAR]) begin
                            aerr_q <= 1'b0;
                            ovr_q  <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
                            tmo_q  <= 1'b0;
`endif
                        end
                        if (ctrl_reg[CTRL_COMMIT]) begin
                            state_q   <= ST_WAIT_SYNC;
`ifdef FIR_SEQ_TIMEOUT_EN
                            tmo_cnt_q <= TMO_W'(SYNC_TIMEOUT - 1);
`endif
                        end else if (cmd_addr < PAIR_LIMIT) begin
                            state_q <= ST_WRITE;
                            we_q    <= 1'b1;
                            addr_q  <= cmd_addr[ADDR_W-1:0];
                            wdata_q <= data_reg[2*COEF_W-1:0];
                            wcnt_q  <= wcnt_q + 8'd1;
                        end else begin
                            state_q <= ST_ACK;
                            aerr_q  <= 1'b1;
                            ack_q   <= ctrl_reg[CTRL_TOGGLE];
                        end
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_ACK;
                    ack_q   <= tog_cap_q;
                end
                ST_WAIT_SYNC: begin
                    if (sync_in) begin
                        state_q  <= ST_SWAP;
                        active_q <= ~active_q;
                    end
`ifdef FIR_SEQ_TIMEOUT_EN
                    // A sync on the terminal cycle wins over the timeout.
                    else if (tmo_cnt_q == '0) begin
                        state_q  <= ST_SWAP;
                        active_q <= ~active_q;
                        tmo_q    <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
                    end
`endif
                end
                ST_SWAP: begin
                    state_q <= ST_ACK;
                    ack_q   <= tog_cap_q;
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign coef_we     = we_q;
    assign coef_bank   = ~active_q;
    assign coef_addr   = addr_q;
    assign coef_wdata  = wdata_q;
    assign active_bank = active_q;

    always_comb begin
        status_out                         = '0;
        status_out[STAT_ACK]               = ack_q;
        status_out[STAT_BUSY]              = (state_q != ST_IDLE);
        status_out[STAT_BANK]              = active_q;
        status_out[STAT_TMO]               = tmo_flag;
        status_out[STAT_AERR]              = aerr_q;
        status_out[STAT_OVR_LSB +: 8]      = ovr_q;
        status_out[STAT_WCNT_LSB +: 8]     = wcnt_q;
    end

endmodule
